// File: rtl/input_debounce_sync.sv
// input_debounce_sync: conditions raw board inputs (buttons and DIP switches)
// for the core. Each channel passes through a 2-flop synchroniser and an
// N-sample debounce filter. A shared prescaler sets the sample rate. Each
// channel produces a clean level and one-cycle rise/fall event pulses.
module input_debounce_sync #(
  parameter int WIDTH = 9,
  parameter int N     = 4,
  parameter int RATE  = 125000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             tick
);

  // The prescaler needs at least one bit, even when RATE is 1 and the count
  // never leaves zero.
  localparam int CW = (RATE > 1) ? $clog2(RATE) : 1;

  logic [CW-1:0]             r_count;
  logic [WIDTH-1:0]          r_sync1;
  logic [WIDTH-1:0]          r_sync2;
  logic [WIDTH-1:0][N-1:0]   r_sr;
  logic [WIDTH-1:0]          r_out;
  logic [WIDTH-1:0]          r_rise;
  logic [WIDTH-1:0]          r_fall;

  logic                      w_hit;
  logic                      w_tick;
  logic [WIDTH-1:0][N-1:0]   w_nxt;
  logic [WIDTH-1:0]          w_all1;
  logic [WIDTH-1:0]          w_all0;

  // Terminal count of the prescaler. With RATE=1 the count is always zero,
  // so this is true every cycle. Gating with rst keeps tick low while reset
  // is held, even in that degenerate case.
  assign w_hit  = (r_count == CW'(RATE - 1));
  assign w_tick = w_hit & ~rst;
  assign tick   = w_tick;

  // Prescaler: count 0..RATE-1 and wrap to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_hit) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(1);
    end
  end

  // Two-flop synchroniser. Every channel is treated as asynchronous.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= in;
      r_sync2 <= r_sync1;
    end
  end

  // Post-shift sample window per channel, plus the unanimous-window flags.
  always_comb begin
    w_nxt  = '0;
    w_all1 = '0;
    w_all0 = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_nxt[i]  = {r_sr[i][N-2:0], r_sync2[i]};
      w_all1[i] = &w_nxt[i];
      w_all0[i] = ~|w_nxt[i];
    end
  end

  // Sample on each tick and update the level. Event pulses are registered
  // together with the level, so a pulse coincides with the new level.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr   <= '0;
      r_out  <= '0;
      r_rise <= '0;
      r_fall <= '0;
    end else if (w_tick) begin
      r_sr   <= w_nxt;
      r_out  <= (r_out | w_all1) & ~w_all0;
      r_rise <= w_all1 & ~r_out;
      r_fall <= w_all0 & r_out;
    end else begin
      r_rise <= '0;
      r_fall <= '0;
    end
  end

  assign out  = r_out;
  assign rise = r_rise;
  assign fall = r_fall;

endmodule

// File: tb/tb_input_debounce_sync.sv
// Directed bench for input_debounce_sync.
// dut_a uses N=3 and RATE=4. dut_b uses N=2 and RATE=1.
// Edge numbers in the comments count rising edges after reset release.
// Inputs are driven 1 ns after an edge, and outputs are sampled at the same
// point.
module tb_input_debounce_sync;

  localparam int W = 9;

  logic         clk = 1'b0;
  logic         rst_a;
  logic         rst_b;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [W-1:0] out_a;
  logic [W-1:0] rise_a;
  logic [W-1:0] fall_a;
  logic [W-1:0] out_b;
  logic [W-1:0] rise_b;
  logic [W-1:0] fall_b;
  logic         tick_a;
  logic         tick_b;

  int n_cmp = 0;
  int n_err = 0;

  // clock / reset block
  always #5 clk = ~clk;

  input_debounce_sync #(.WIDTH(W), .N(3), .RATE(4)) dut_a (
    .clk  (clk),
    .rst  (rst_a),
    .in   (in_a),
    .out  (out_a),
    .rise (rise_a),
    .fall (fall_a),
    .tick (tick_a)
  );

  input_debounce_sync #(.WIDTH(W), .N(2), .RATE(1)) dut_b (
    .clk  (clk),
    .rst  (rst_b),
    .in   (in_b),
    .out  (out_b),
    .rise (rise_b),
    .fall (fall_b),
    .tick (tick_b)
  );

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // driver task: advance one rising edge, then settle 1 ns
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    in_a  = 9'h1FF;
    in_b  = 9'h000;
    repeat (3) step();

    // reset state
    check_val("rst_out_a",  32'(out_a),  32'h0);
    check_val("rst_rise_a", 32'(rise_a), 32'h0);
    check_val("rst_fall_a", 32'(fall_a), 32'h0);
    check_val("rst_tick_a", 32'(tick_a), 32'h0);
    check_val("rst_cnt_a",  32'(dut_a.r_count), 32'h0);
    check_val("rst_out_b",  32'(out_b),  32'h0);
    check_val("rst_tick_b", 32'(tick_b), 32'h0);
    rst_a = 1'b0;
    rst_b = 1'b0;

    // power-up with steady-high input: ticks at 4, 8, 12; out and rise at 12
    for (int e = 1; e <= 13; e++) begin
      step();
      check_val("pu_out",  32'(out_a),  (e >= 12) ? 32'h1FF : 32'h0);
      check_val("pu_rise", 32'(rise_a), (e == 12) ? 32'h1FF : 32'h0);
      check_val("pu_fall", 32'(fall_a), 32'h0);
      check_val("pu_tick", 32'(tick_a), (e % 4 == 3) ? 32'h1 : 32'h0);
    end
    step();  // edge 14

    // Bounce pattern on in[0]: low 5, high 3, low 6, then high.
    // The pattern starts at edge 15. Ticks sample sync2, which lags in by
    // two edges, so the samples are 1,0,1,0,1 and no window is all zeros.
    for (int t = 0; t < 20; t++) begin
      in_a[0] = (t < 5) ? 1'b0 : (t < 8) ? 1'b1 : (t < 14) ? 1'b0 : 1'b1;
      step();
      check_val("bnc_out",  32'(out_a),  32'h1FF);
      check_val("bnc_fall", 32'(fall_a), 32'h0);
    end

    // Clean release on in[0], starting after edge 34. The zero samples come
    // at edges 40, 44 and 48, so fall fires at 48.
    in_a[0] = 1'b0;
    for (int e = 35; e <= 50; e++) begin
      step();
      check_val("rel_out",  32'(out_a),  (e >= 48) ? 32'h1FE : 32'h1FF);
      check_val("rel_fall", 32'(fall_a), (e == 48) ? 32'h001 : 32'h0);
      check_val("rel_rise", 32'(rise_a), 32'h0);
    end

    // Release channel 5 so it can be pressed later: fall at edge 64.
    in_a[5] = 1'b0;
    for (int e = 51; e <= 64; e++) begin
      step();
      check_val("c5_out",  32'(out_a),  (e >= 64) ? 32'h1DE : 32'h1FE);
      check_val("c5_fall", 32'(fall_a), (e == 64) ? 32'h020 : 32'h0);
    end

    // Simultaneous events: channel 2 released and channel 5 pressed.
    // Both events land at edge 76.
    in_a = 9'h1FA;
    for (int e = 65; e <= 77; e++) begin
      step();
      check_val("sim_out",  32'(out_a),  (e >= 76) ? 32'h1FA : 32'h1DE);
      check_val("sim_rise", 32'(rise_a), (e == 76) ? 32'h020 : 32'h0);
      check_val("sim_fall", 32'(fall_a), (e == 76) ? 32'h004 : 32'h0);
    end

    // Move to out = 01F: bits 0 and 2 rise, bits 5..8 fall, all at edge 88.
    in_a = 9'h01F;
    for (int e = 78; e <= 89; e++) begin
      step();
      check_val("m_out",  32'(out_a),  (e >= 88) ? 32'h01F : 32'h1FA);
      check_val("m_rise", 32'(rise_a), (e == 88) ? 32'h005 : 32'h0);
      check_val("m_fall", 32'(fall_a), (e == 88) ? 32'h1E0 : 32'h0);
    end
    step();  // edge 90

    // Mid-operation reset for one cycle: everything clears with no fall pulse.
    rst_a = 1'b1;
    step();
    check_val("mr_out",  32'(out_a),  32'h0);
    check_val("mr_rise", 32'(rise_a), 32'h0);
    check_val("mr_fall", 32'(fall_a), 32'h0);
    check_val("mr_tick", 32'(tick_a), 32'h0);
    check_val("mr_cnt",  32'(dut_a.r_count), 32'h0);
    rst_a = 1'b0;
    for (int e = 1; e <= 13; e++) begin
      step();
      check_val("mr2_out",  32'(out_a),  (e >= 12) ? 32'h01F : 32'h0);
      check_val("mr2_rise", 32'(rise_a), (e == 12) ? 32'h01F : 32'h0);
      check_val("mr2_fall", 32'(fall_a), 32'h0);
      check_val("mr2_tick", 32'(tick_a), (e % 4 == 3) ? 32'h1 : 32'h0);
    end

    // RATE=1, N=2: a step on in[3] shows on out 4 edges after the change.
    in_b[3] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      check_val("r1_out",  32'(out_b),  (k >= 4) ? 32'h008 : 32'h0);
      check_val("r1_rise", 32'(rise_b), (k == 4) ? 32'h008 : 32'h0);
      check_val("r1_fall", 32'(fall_b), 32'h0);
      check_val("r1_tick", 32'(tick_b), 32'h1);
    end

    // 1-cycle glitches: a low glitch on channel 3 and a high glitch on
    // channel 0. Neither changes out.
    in_b[3] = 1'b0;
    in_b[0] = 1'b1;
    step();
    in_b[3] = 1'b1;
    in_b[0] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      check_val("gl_out",  32'(out_b),  32'h008);
      check_val("gl_rise", 32'(rise_b), 32'h0);
      check_val("gl_fall", 32'(fall_b), 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
